// File: rtl/vga_pic_bounce_if.sv
// Pixel request/response bundle between vga_ctrl and the bouncing-square pixel source.
// master: timing side (drives coordinates and move_en); slave: the pixel source.
interface vga_pic_bounce_if;
  logic        move_en;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic [9:0]  box_x;
  logic [9:0]  box_y;

  modport master (
    output move_en, pix_x, pix_y,
    input  pix_data, box_x, box_y
  );

  modport slave (
    input  move_en, pix_x, pix_y,
    output pix_data, box_x, box_y
  );
endinterface

// File: rtl/vga_pic_bounce.sv
// Colour-bar pixel source with a bouncing square, updated once per frame on the last active pixel.
// Optional 1-px white frame around the active area: define VGA_PIC_BORDER_EN.
//
// dir state | meaning
// DIR_FWD   | axis position increasing (right / down)
// DIR_REV   | axis position decreasing (left / up)
module vga_pic_bounce #(
  parameter int          H_VALID   = 640,
  parameter int          V_VALID   = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter logic [15:0] BOX_COLOR = 16'hFC00
) (
  input  logic            vga_clk,
  input  logic            sys_rst,
  vga_pic_bounce_if.slave bus
);

  localparam int          BAR_W  = H_VALID / 8;
  localparam logic [10:0] H_LIM  = 11'(H_VALID);
  localparam logic [10:0] V_LIM  = 11'(V_VALID);
  localparam logic [10:0] X_MAX  = 11'(H_VALID - BOX_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_VALID - BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

  generate
    if (BOX_SIZE >= H_VALID || BOX_SIZE >= V_VALID || STEP < 1) begin : g_param_err
      $error("vga_pic_bounce: need BOX_SIZE < H_VALID, BOX_SIZE < V_VALID, STEP >= 1");
    end
  endgenerate

  typedef enum logic {DIR_FWD, DIR_REV} dir_e;

  logic [15:0] pix_data_q, pix_data_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  dir_e        dir_x_q, dir_x_d;
  dir_e        dir_y_q, dir_y_d;

  logic [10:0] px, py, bx, by;
  logic        active, in_box, frame_end;
  logic [15:0] bar_color;

  // All geometry in 11 bits so box+size and box+step never wrap.
  assign px = {1'b0, bus.pix_x};
  assign py = {1'b0, bus.pix_y};
  assign bx = {1'b0, box_x_q};
  assign by = {1'b0, box_y_q};

  assign active    = (px < H_LIM) && (py < V_LIM);
  assign in_box    = (px >= bx) && (px < bx + BOX_W) && (py >= by) && (py < by + BOX_W);
  assign frame_end = (px == H_LIM - 11'd1) && (py == V_LIM - 11'd1);

`ifdef VGA_PIC_BORDER_EN
  logic border;
  assign border = (px == 11'd0) || (px == H_LIM - 11'd1) ||
                  (py == 11'd0) || (py == V_LIM - 11'd1);
`endif

  always_comb begin
    bar_color = 16'hFFFF;
    if      (px < 11'(1 * BAR_W)) bar_color = 16'h0000;
    else if (px < 11'(2 * BAR_W)) bar_color = 16'h001F;
    else if (px < 11'(3 * BAR_W)) bar_color = 16'hF800;
    else if (px < 11'(4 * BAR_W)) bar_color = 16'hF81F;
    else if (px < 11'(5 * BAR_W)) bar_color = 16'h07E0;
    else if (px < 11'(6 * BAR_W)) bar_color = 16'h07FF;
    else if (px < 11'(7 * BAR_W)) bar_color = 16'hFFE0;
  end

  always_comb begin
    pix_data_d = 16'h0000;
    box_x_d    = box_x_q;
    box_y_d    = box_y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;

    if (active) begin
      pix_data_d = bar_color;
`ifdef VGA_PIC_BORDER_EN
      if (border) pix_data_d = 16'hFFFF;
`endif
      if (in_box) pix_data_d = BOX_COLOR;
    end

    // The frame_end pixel is the last active one, so a move never lands mid-picture.
    if (frame_end && bus.move_en) begin
      if (dir_x_q == DIR_FWD) begin
        if (bx + STEP_W >= X_MAX) begin
          box_x_d = X_MAX[9:0];
          dir_x_d = DIR_REV;
        end else begin
          box_x_d = 10'(bx + STEP_W);
        end
      end else begin
        if (bx <= STEP_W) begin
          box_x_d = 10'd0;
          dir_x_d = DIR_FWD;
        end else begin
          box_x_d = 10'(bx - STEP_W);
        end
      end

      if (dir_y_q == DIR_FWD) begin
        if (by + STEP_W >= Y_MAX) begin
          box_y_d = Y_MAX[9:0];
          dir_y_d = DIR_REV;
        end else begin
          box_y_d = 10'(by + STEP_W);
        end
      end else begin
        if (by <= STEP_W) begin
          box_y_d = 10'd0;
          dir_y_d = DIR_FWD;
        end else begin
          box_y_d = 10'(by - STEP_W);
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      pix_data_q <= 16'h0000;
      box_x_q    <= 10'd0;
      box_y_q    <= 10'd0;
      dir_x_q    <= DIR_FWD;
      dir_y_q    <= DIR_FWD;
    end else begin
      pix_data_q <= pix_data_d;
      box_x_q    <= box_x_d;
      box_y_q    <= box_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
    end
  end

  assign bus.pix_data = pix_data_q;
  assign bus.box_x    = box_x_q;
  assign bus.box_y    = box_y_q;

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Scoreboard bench for vga_pic_bounce: driver queues expectations, a monitor compares one cycle later.
module tb_vga_pic_bounce;
  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;

  vga_pic_bounce_if bus ();

  vga_pic_bounce dut (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int          due;
    string       name;
    bit          chk_pix;
    logic [15:0] pix;
    bit          chk_box;
    logic [9:0]  bx;
    logic [9:0]  by;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  // Monitor: one sample per clock, 1 time unit after the rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge vga_clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.chk_pix) begin
          checks++;
          if (bus.pix_data !== e.pix) begin
            failures++;
            $display("FAIL %s pix_data got=%h exp=%h", e.name, bus.pix_data, e.pix);
          end
        end
        if (e.chk_box) begin
          checks++;
          if (bus.box_x !== e.bx) begin
            failures++;
            $display("FAIL %s box_x got=%0d exp=%0d", e.name, bus.box_x, e.bx);
          end
          checks++;
          if (bus.box_y !== e.by) begin
            failures++;
            $display("FAIL %s box_y got=%0d exp=%0d", e.name, bus.box_y, e.by);
          end
        end
      end
    end
  end

  // Inputs change on the falling edge; the result is due after the next rising edge.
  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic men,
                       input logic rst, input string nm, input bit cp,
                       input logic [15:0] p, input bit cb,
                       input logic [9:0] ex, input logic [9:0] ey);
    exp_t e;
    @(negedge vga_clk);
    bus.pix_x   = x;
    bus.pix_y   = y;
    bus.move_en = men;
    sys_rst     = rst;
    if (cp || cb) begin
      e.due     = cyc + 1;
      e.name    = nm;
      e.chk_pix = cp;
      e.pix     = p;
      e.chk_box = cb;
      e.bx      = ex;
      e.by      = ey;
      sb.push_back(e);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y,
                     input logic [15:0] p, input string nm);
    drive(x, y, 1'b0, 1'b0, nm, 1'b1, p, 1'b0, 10'd0, 10'd0);
  endtask

  task automatic strobe(input logic men, input bit cb, input logic [9:0] ex,
                        input logic [9:0] ey, input string nm);
    drive(10'd639, 10'd479, men, 1'b0, nm, 1'b0, 16'h0000, cb, ex, ey);
  endtask

  // Hand-computed trajectory checkpoints (frame, box_x, box_y).
  int ck_f[13] = '{1, 2, 224, 225, 303, 304, 305, 447, 448, 449, 608, 609, 610};
  int ck_x[13] = '{2, 4, 448, 450, 606, 608, 606, 322, 320, 318,   0,   2,   4};
  int ck_y[13] = '{2, 4, 448, 446, 290, 288, 286,   2,   0,   2, 320, 322, 324};

  logic [15:0] exp_border;

  initial begin : stim
    bit cb;
    logic [9:0] ex, ey;
`ifdef VGA_PIC_BORDER_EN
    exp_border = 16'hFFFF;
`else
    exp_border = 16'h0000;
`endif
    bus.pix_x   = 10'd10;
    bus.pix_y   = 10'd10;
    bus.move_en = 1'b1;
    sys_rst     = 1'b1;

    // Reset held: a square pixel and a frame_end strobe must both be ignored.
    for (int i = 0; i < 4; i++)
      drive(10'd10, 10'd10, 1'b1, 1'b1, "rst_hold", 1'b1, 16'h0000, 1'b1, 10'd0, 10'd0);
    drive(10'd639, 10'd479, 1'b1, 1'b1, "rst_strobe", 1'b1, 16'h0000, 1'b1, 10'd0, 10'd0);
    drive(10'h3FF, 10'h3FF, 1'b0, 1'b0, "rst_release", 1'b1, 16'h0000, 1'b1, 10'd0, 10'd0);

    // Bars and square with box at (0,0).
    pix(10'd85,  10'd200, 16'h001F, "bar1");
    pix(10'd600, 10'd200, 16'hFFFF, "bar7");
    pix(10'd10,  10'd10,  16'hFC00, "box_in");
    pix(10'd32,  10'd10,  16'h0000, "box_right_out");
    pix(10'd31,  10'd31,  16'hFC00, "box_corner");
    pix(10'd31,  10'd32,  16'h0000, "box_below_out");
    pix(10'd79,  10'd100, 16'h0000, "bar0_last");
    pix(10'd80,  10'd100, 16'h001F, "bar1_first");
    pix(10'd160, 10'd100, 16'hF800, "bar2");
    pix(10'd240, 10'd100, 16'hF81F, "bar3");
    pix(10'd320, 10'd100, 16'h07E0, "bar4");
    pix(10'd400, 10'd100, 16'h07FF, "bar5");
    pix(10'd559, 10'd100, 16'hFFE0, "bar6_last");
    pix(10'd560, 10'd100, 16'hFFFF, "bar7_first");
    pix(10'h3FF, 10'd100, 16'h0000, "blank_x");
    pix(10'd100, 10'd480, 16'h0000, "blank_y480");
    pix(10'd0,   10'd300, exp_border, "edge_left");
    pix(10'd300, 10'd0,   (exp_border == 16'hFFFF) ? 16'hFFFF : 16'hF81F, "edge_top");
    pix(10'd300, 10'd479, (exp_border == 16'hFFFF) ? 16'hFFFF : 16'hF81F, "edge_bottom");

    // Single move, then a held frame.
    strobe(1'b1, 1'b1, 10'd2, 10'd2, "move_once");
    strobe(1'b0, 1'b1, 10'd2, 10'd2, "move_hold");
    pix(10'd2,  10'd2,  16'hFC00, "moved_tl");
    pix(10'd33, 10'd33, 16'hFC00, "moved_br");
    pix(10'd34, 10'd20, 16'h0000, "moved_right_out");

    // Reset asserted mid-frame restores the origin.
    drive(10'd100, 10'd100, 1'b0, 1'b1, "mid_reset", 1'b1, 16'h0000, 1'b1, 10'd0, 10'd0);

    // Long run through both bounces on each axis.
    for (int f = 1; f <= 610; f++) begin
      cb = 1'b0;
      ex = 10'd0;
      ey = 10'd0;
      for (int k = 0; k < 13; k++) begin
        if (ck_f[k] == f) begin
          cb = 1'b1;
          ex = 10'(ck_x[k]);
          ey = 10'(ck_y[k]);
        end
      end
      strobe(1'b1, cb, ex, ey, "bounce_run");
    end
    pix(10'd4,  10'd324, 16'hFC00, "final_tl");
    pix(10'd35, 10'd355, 16'hFC00, "final_br");
    pix(10'd36, 10'd355, 16'h0000, "final_right_out");

    repeat (3) @(negedge vga_clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
